// File: rtl/audio_in_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_level_meter
// Purpose  : Drains L/R samples from the audio-in FIFO and publishes the
//            windowed peak magnitude plus a 6 dB/step thermometer bar.
// Revision : 1.0 - initial release
// ============================================================================
module audio_in_level_meter #(
    parameter int unsigned WINDOW = 4800
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        clear_audio_in_memory,
    output logic [30:0] peak,
    output logic [9:0]  level,
    output logic        level_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic [15:0] c_LAST = 16'(WINDOW - 1);

    // -2^31 has no positive 31-bit counterpart, so it saturates.
    function automatic logic [30:0] f_abs(input logic [31:0] x);
        logic [31:0] neg;
        neg = ~x + 32'd1;
        if (!x[31])
            return x[30:0];
        else if (x[30:0] == 31'd0)
            return 31'h7FFF_FFFF;
        else
            return neg[30:0];
    endfunction

    state_t      r_state_q,    w_state_d;
    logic [15:0] r_cnt_q,      w_cnt_d;
    logic [30:0] r_peak_acc_q, w_peak_acc_d;
    logic [30:0] r_peak_q,     w_peak_d;
    logic [9:0]  r_level_q,    w_level_d;
    logic        r_lv_q,       w_lv_d;
    logic        r_read_q,     w_read_d;
    logic        r_clear_q,    w_clear_d;

    logic [30:0] w_mag_l, w_mag_r, w_mag, w_acc_max;
    logic        w_capture, w_close;

    always_comb begin
        w_mag_l   = f_abs(left_channel_audio_in);
        w_mag_r   = f_abs(right_channel_audio_in);
        w_mag     = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;
        w_acc_max = (r_peak_acc_q > w_mag) ? r_peak_acc_q : w_mag;
        // The pair is taken from the ports during the POP cycle itself.
        w_capture = (r_state_q == S_POP) && enable;
        w_close   = w_capture && (r_cnt_q == c_LAST);

        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:   if (audio_in_available) w_state_d = S_POP;
            S_POP:    w_state_d = S_SETTLE;
            S_SETTLE: w_state_d = S_IDLE;
            default:  w_state_d = S_IDLE;
        endcase
        if (!enable)
            w_state_d = S_IDLE;

        w_cnt_d      = r_cnt_q;
        w_peak_acc_d = r_peak_acc_q;
        if (!enable) begin
            w_cnt_d      = 16'd0;
            w_peak_acc_d = 31'd0;
        end else if (w_capture) begin
            w_cnt_d      = w_close ? 16'd0 : r_cnt_q + 16'd1;
            w_peak_acc_d = w_close ? 31'd0 : w_acc_max;
        end

        w_peak_d = w_close ? w_acc_max : r_peak_q;
        for (int i = 0; i < 10; i++)
            w_level_d[i] = ((w_peak_d >> (21 + i)) != 31'd0);

        w_lv_d    = w_close;
        w_read_d  = (w_state_d == S_POP);
        w_clear_d = ~enable;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state_q    <= S_IDLE;
            r_cnt_q      <= 16'd0;
            r_peak_acc_q <= 31'd0;
            r_peak_q     <= 31'd0;
            r_level_q    <= 10'd0;
            r_lv_q       <= 1'b0;
            r_read_q     <= 1'b0;
            r_clear_q    <= 1'b1;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_peak_acc_q <= w_peak_acc_d;
            r_peak_q     <= w_peak_d;
            r_level_q    <= w_level_d;
            r_lv_q       <= w_lv_d;
            r_read_q     <= w_read_d;
            r_clear_q    <= w_clear_d;
        end
    end

    assign read_audio_in         = r_read_q;
    assign clear_audio_in_memory = r_clear_q;
    assign peak                  = r_peak_q;
    assign level                 = r_level_q;
    assign level_valid           = r_lv_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_in_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_in_level_meter
// Purpose  : Directed self-checking bench; one meter with WINDOW=4 and one
//            with WINDOW=2 share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_in_level_meter;

    logic        clk = 1'b0;
    logic        resetn, enable, avail;
    logic [31:0] l_in, r_in;
    logic        rd4, clr4, lv4, rd2, clr2, lv2;
    logic [30:0] peak4, peak2;
    logic [9:0]  level4, level2;

    int n_checks = 0;
    int n_fail   = 0;
    logic lv4_seen, lv2_seen;
    int rd_cnt, b2b, lvc4, lvc2;
    logic prev_rd;

    always #5 clk = ~clk;

    audio_in_level_meter #(.WINDOW(4)) u4 (
        .clock(clk), .resetn(resetn), .enable(enable),
        .audio_in_available(avail),
        .left_channel_audio_in(l_in), .right_channel_audio_in(r_in),
        .read_audio_in(rd4), .clear_audio_in_memory(clr4),
        .peak(peak4), .level(level4), .level_valid(lv4)
    );

    audio_in_level_meter #(.WINDOW(2)) u2 (
        .clock(clk), .resetn(resetn), .enable(enable),
        .audio_in_available(avail),
        .left_channel_audio_in(l_in), .right_channel_audio_in(r_in),
        .read_audio_in(rd2), .clear_audio_in_memory(clr2),
        .peak(peak2), .level(level2), .level_valid(lv2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Offers one pair, checks the single pop pulse and notes level_valid.
    task automatic push(input logic [31:0] l, input logic [31:0] r);
        avail = 1'b1;
        l_in  = l;
        r_in  = r;
        step;
        chk("pop_pulse", {31'd0, rd4}, 32'd1);
        avail = 1'b0;
        step;
        lv4_seen = lv4;
        lv2_seen = lv2;
        step;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        step;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; avail = 1'b0; l_in = '0; r_in = '0;
        step; step;
        chk("rst_read",  {31'd0, rd4},   32'd0);
        chk("rst_clear", {31'd0, clr4},  32'd1);
        chk("rst_peak",  {1'b0, peak4},  32'd0);
        chk("rst_level", {22'd0, level4}, 32'd0);
        chk("rst_lv",    {31'd0, lv4},   32'd0);

        // Enabled but nothing available: meter stays silent.
        resetn = 1'b1; enable = 1'b1;
        step;
        chk("clear_follow_en", {31'd0, clr4}, 32'd0);
        rd_cnt = 0; lvc4 = 0;
        for (int k = 0; k < 100; k++) begin
            step;
            if (rd4) rd_cnt++;
            if (lv4) lvc4++;
            if (clr4) lvc4++;
        end
        chk("idle_reads", rd_cnt, 0);
        chk("idle_lv_or_clear", lvc4, 0);
        chk("idle_peak", {1'b0, peak4}, 32'd0);

        // Continuous availability: one pop every third cycle.
        avail = 1'b1; l_in = '0; r_in = '0;
        rd_cnt = 0; b2b = 0; lvc4 = 0; lvc2 = 0; prev_rd = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step;
            if (rd4 && prev_rd) b2b++;
            if (rd4) rd_cnt++;
            prev_rd = rd4;
            if (lv4) lvc4++;
            if (lv2) lvc2++;
        end
        avail = 1'b0;
        step;
        chk("cadence_pops", rd_cnt, 10);
        chk("cadence_b2b", b2b, 0);
        chk("cadence_lv_w4", lvc4, 2);
        chk("cadence_lv_w2", lvc2, 5);
        do_reset;

        // Peak tracking including the saturating -2^31 case.
        push(32'd100, -32'sd5000);
        push(32'h8000_0000, 32'd0);
        push(32'd7, 32'd7);
        chk("w4_no_early_lv", {31'd0, lv4_seen}, 32'd0);
        push(32'd0, 32'd0);
        chk("sat_lv",    {31'd0, lv4_seen}, 32'd1);
        chk("sat_peak",  {1'b0, peak4},   32'h7FFF_FFFF);
        chk("sat_level", {22'd0, level4}, 32'h0000_03FF);
        chk("lv_one_cycle", {31'd0, lv4}, 32'd0);
        push(32'd0, 32'd0);
        push(32'd0, 32'd0);
        push(32'h0030_0000, 32'd0);
        push(32'd0, 32'd0);
        chk("w2_peak",  {1'b0, peak4},   32'h0030_0000);
        chk("w2_level", {22'd0, level4}, 32'h0000_0001);

        // Enable drop mid-window discards the partial window.
        push(32'h4000_0000, 32'd0);
        push(32'd0, 32'hC000_0000);
        enable = 1'b0; avail = 1'b1;
        step;
        chk("drop_clear", {31'd0, clr4}, 32'd1);
        rd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step;
            if (rd4) rd_cnt++;
        end
        chk("drop_no_reads", rd_cnt, 0);
        chk("drop_peak_hold",  {1'b0, peak4},   32'h0030_0000);
        chk("drop_level_hold", {22'd0, level4}, 32'h0000_0001);
        enable = 1'b1; avail = 1'b0;
        step;
        chk("reenable_clear", {31'd0, clr4}, 32'd0);
        push(32'd0, 32'd0);
        push(32'd0, 32'd0);
        push(32'd0, 32'd0);
        chk("reen_no_early_lv", {31'd0, lv4_seen}, 32'd0);
        push(32'd0, 32'd0);
        chk("reen_lv",   {31'd0, lv4_seen}, 32'd1);
        chk("reen_peak", {1'b0, peak4}, 32'd0);

        // Reset after 3 of 4 pairs.
        push(32'h4000_0000, 32'd0);
        push(32'h4000_0000, 32'd0);
        chk("pre_rst_peak_w2", {1'b0, peak2}, 32'h4000_0000);
        push(32'h4000_0000, 32'd0);
        do_reset;
        chk("mid_rst_peak_w2",  {1'b0, peak2},   32'd0);
        chk("mid_rst_level_w2", {22'd0, level2}, 32'd0);
        chk("mid_rst_clear",    {31'd0, clr4},   32'd1);
        chk("mid_rst_read",     {31'd0, rd4},    32'd0);

        // Fresh window; the WINDOW=2 meter also checks left/right max.
        push(32'd0, 32'hFF00_0000);
        chk("lr_no_early_lv", {31'd0, lv2_seen}, 32'd0);
        push(32'h0020_0000, 32'd0);
        chk("lr_lv",    {31'd0, lv2_seen}, 32'd1);
        chk("lr_peak",  {1'b0, peak2},   32'h0100_0000);
        chk("lr_level", {22'd0, level2}, 32'h0000_000F);
        push(32'd0, 32'd0);
        chk("fresh_no_early_lv", {31'd0, lv4_seen}, 32'd0);
        chk("fresh_peak_pre",    {1'b0, peak4},   32'd0);
        push(32'd0, 32'd0);
        chk("fresh_lv",    {31'd0, lv4_seen}, 32'd1);
        chk("fresh_peak",  {1'b0, peak4},   32'h0100_0000);
        chk("fresh_level", {22'd0, level4}, 32'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
